// File: rtl/hbif_cmd_ctrl.sv
// Host command-frame decoder: turns {we, addr[6:0]} [+ data] byte frames into
// single-cycle register-file strobes and answers every completed frame with one byte.
module hbif_cmd_ctrl #(
  parameter int DEPTH          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [7:0]            rsp_data_o,
  output logic                  rf_en_o,
  output logic                  rf_we_o,
  output logic [ADDR_W-1:0]     rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic [7:0]            err_cnt_o,
  output logic                  busy_o
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      DEPTH_LIM = 8'(DEPTH);
  localparam logic [7:0]      RSP_OK    = 8'hA5;
  localparam logic [7:0]      RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_e;

  state_e                r_state;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic                  r_busy;
  logic                  r_rf_en;
  logic                  r_rf_we;
  logic                  r_addr_ok;
  logic [7:0]            r_rsp_data;
  logic [7:0]            r_err_cnt;
  logic [ADDR_W-1:0]     r_rf_addr;
  logic [DATA_WIDTH-1:0] r_rf_wdata;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_hdr_addr_ok;
  logic [7:0]            w_err_inc;
  logic [7:0]            w_rdata_ext;

  // All seven header address bits take part, so aliases above DEPTH are rejected.
  assign w_hdr_addr_ok = {1'b0, cmd_data_i[6:0]} < DEPTH_LIM;
  assign w_err_inc     = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
  assign w_rdata_ext   = 8'(rf_rdata_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rf_en     <= 1'b0;
      r_rf_we     <= 1'b0;
      r_addr_ok   <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_err_cnt   <= 8'h00;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_to_cnt    <= '0;
    end else begin
      // NOTE: non-blocking defaults here make the strobes one-cycle pulses; any
      // state below that re-asserts them simply overrides the default.
      r_rf_en <= 1'b0;
      r_rf_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_busy    <= 1'b1;
            r_addr_ok <= w_hdr_addr_ok;
            r_rf_addr <= cmd_data_i[ADDR_W-1:0];
            if (cmd_data_i[7]) begin
              r_state  <= S_WDATA;
              r_to_cnt <= '0;
            end else if (w_hdr_addr_ok) begin
              r_state     <= S_RD_ISSUE;
              r_cmd_ready <= 1'b0;
              r_rf_en     <= 1'b1;
            end else begin
              r_state     <= S_RESP;
              r_cmd_ready <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= RSP_ERR;
              r_err_cnt   <= w_err_inc;
            end
          end
        end
        S_WDATA: begin
          if (cmd_valid_i) begin
            r_rf_wdata  <= cmd_data_i[DATA_WIDTH-1:0];
            r_cmd_ready <= 1'b0;
            if (r_addr_ok) begin
              r_state <= S_WRITE;
              r_rf_en <= 1'b1;
              r_rf_we <= 1'b1;
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= RSP_ERR;
              r_err_cnt   <= w_err_inc;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Abandoned write: drop silently, only the error counter records it.
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_to_cnt  <= '0;
            r_err_cnt <= w_err_inc;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= RSP_OK;
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_rdata_ext;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rf_en_o     = r_rf_en;
  assign rf_we_o     = r_rf_we;
  assign rf_addr_o   = r_rf_addr;
  assign rf_wdata_o  = r_rf_wdata;
  assign err_cnt_o   = r_err_cnt;
  assign busy_o      = r_busy;

endmodule
